// File: rtl/reg_readback_tx_pkg.sv
// Shared UART transmit definitions: FSM state encoding and bit-period helper.
// Used by the register readback transmitter and its matching receiver.
package reg_readback_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // Truncating division: the line runs marginally fast rather than slow.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/reg_readback_tx_byte_fifo.sv
// Byte-wide synchronous FIFO: registered level, data visible at head combinationally.
// Latency 1 cycle push-to-pop; caller must only push when not full (or when popping) and pop when non-empty.
module reg_readback_tx_byte_fifo
    import reg_readback_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [7:0]                   dat_i,
    output logic [7:0]                   dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    // Level is counted directly so full and empty never alias on equal pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign dat_o   = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/reg_readback_tx.sv
// Register readback return path: captures read data after each strobe, queues it, sends 8N1 UART.
// Latency READ_LATENCY+1 edges strobe-to-start-bit; no backpressure, a byte arriving at a full queue is dropped and flagged sticky.
module reg_readback_tx
    import reg_readback_tx_pkg::*;
#(
    parameter int CLK_HZ       = 27_000_000,
    parameter int BAUD         = 115200,
    parameter int FIFO_DEPTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                               clkin,
    input  logic                               reset,
    input  logic                               reg_read,
    input  logic [7:0]                         reg_data_out,
    output logic                               tx,
    output logic                               busy,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int LVL_W        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [READ_LATENCY-1:0] strb_q;
    uart_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [7:0]              shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    overflow_q, overflow_d;

    logic                    push;
    logic                    push_ok;
    logic                    pop;
    logic [7:0]              fifo_dat;
    logic [LVL_W-1:0]        fifo_lvl;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    lvl_nz_d;

    always_ff @(posedge clkin) begin
        if (!reset) begin
            strb_q <= '0;
        end else begin
            strb_q[0] <= reg_read;
            for (int i = 1; i < READ_LATENCY; i++) begin
                strb_q[i] <= strb_q[i-1];
            end
        end
    end

    // A pop on the same edge frees the slot, so a full queue still takes the byte.
    assign push    = strb_q[READ_LATENCY-1];
    assign push_ok = push & (~fifo_full | pop);

    reg_readback_tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clkin),
        .rst_n_i (reset),
        .push_i  (push_ok),
        .pop_i   (pop),
        .dat_i   (reg_data_out),
        .dat_o   (fifo_dat),
        .level_o (fifo_lvl),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dat;
                    cnt_d   = CNT_MAX;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d     = CNT_MAX;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dat;
                        cnt_d   = CNT_MAX;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx and busy are computed from next-state values so they are flop outputs aligned with the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        lvl_nz_d   = push_ok | (pop ? (fifo_lvl > LVL_W'(1)) : ~fifo_empty);
        busy_d     = (state_d != S_IDLE) | lvl_nz_d;
        overflow_d = overflow_q | (push & ~push_ok);
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_level = fifo_lvl;

endmodule

// File: tb/tb_reg_readback_tx.sv
// Bench for reg_readback_tx: table of single-byte frames plus burst, overflow, reset and full-queue sequences.
module tb_reg_readback_tx;

    localparam int CLK_HZ = 27_000_000;
    localparam int BAUD   = 2_700_000;
    localparam int C      = 10;
    localparam int DEPTH  = 16;
    localparam int RL     = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reg_read = 1'b0;
    logic [7:0] reg_data_out = 8'h00;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [4:0] fifo_level;

    reg_readback_tx #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .FIFO_DEPTH   (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clkin        (clk),
        .reset        (reset),
        .reg_read     (reg_read),
        .reg_data_out (reg_data_out),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         frames  = 0;
    logic [7:0] exp_q[$];
    int         starts_q[$];
    logic [7:0] bdat [32];

    typedef struct {
        logic [7:0] dat;
        logic [9:0] line;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line receiver: samples mid-bit on the falling clock edge and checks against the scoreboard.
    initial begin : monitor
        logic [7:0] b;
        logic       st, sp, rs;
        logic [7:0] e;
        int         s;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                s  = cyc;
                rs = 1'b0;
                repeat (C/2) begin @(negedge clk); rs |= (reset !== 1'b1); end
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) begin @(negedge clk); rs |= (reset !== 1'b1); end
                    b[i] = tx;
                end
                repeat (C) begin @(negedge clk); rs |= (reset !== 1'b1); end
                sp = tx;
                if (!rs) begin
                    starts_q.push_back(s);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got byte 0x%0h, expected no frame", b);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("frame%0d", frames), {22'd0, sp, b, st}, {22'd0, 1'b1, e, 1'b0});
                    end
                    frames++;
                end
            end
        end
    end

    task automatic burst(input int n, input int n_acc, output int e0);
        e0 = 0;
        for (int j = 0; j < n_acc; j++) exp_q.push_back(bdat[j]);
        for (int i = 0; i <= n + RL; i++) begin
            @(posedge clk); #1;
            if (i == 0) e0 = cyc + 1;
            reg_read     = (i < n);
            reg_data_out = (i >= RL && i - RL < n) ? bdat[i-RL] : 8'h00;
        end
    endtask

    task automatic step_to(input int edge_id);
        while (cyc + 1 < edge_id) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_drain_timeout"}, (k >= budget), 0);
    endtask

    // Single read with hard-coded RL=2 timing: tx must fall on the third edge after the strobe edge.
    task automatic run_vec(input int idx, input logic [7:0] d, input logic [9:0] line);
        logic [3:0] lat;
        int         bad = 0;
        @(posedge clk); #1; reg_read = 1'b1; exp_q.push_back(d);
        @(posedge clk); #1; reg_read = 1'b0;     lat[0] = tx;
        @(posedge clk); #1; reg_data_out = d;    lat[1] = tx;
        @(posedge clk); #1; reg_data_out = 8'h0; lat[2] = tx;
        @(posedge clk); #1;                      lat[3] = tx;
        chk($sformatf("v%0d_latency", idx), lat, 4'b0111);
        for (int k = 0; k < 10*C; k++) begin
            if (tx !== line[k/C]) bad++;
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_line", idx), bad, 0);
        chk($sformatf("v%0d_idle", idx), {busy, fifo_level}, 0);
    endtask

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e0, er, bad, bad2, f0;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h3C, 10'b1001111000};
        vecs[2] = '{8'h00, 10'b1000000000};
        vecs[3] = '{8'hFF, 10'b1111111110};
        vecs[4] = '{8'h81, 10'b1100000010};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 5; v++) run_vec(v, vecs[v].dat, vecs[v].line);

        // Three back-to-back reads: contiguous frames, busy never drops.
        bdat[0] = 8'h01; bdat[1] = 8'h02; bdat[2] = 8'h03;
        starts_q.delete();
        burst(3, 3, e0);
        bad = 0;
        for (int k = 0; k < 30*C - 1; k++) begin
            if (busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("t2_busy_throughout", bad, 0);
        chk("t2_busy_end", busy, 0);
        chk("t2_frames", starts_q.size(), 3);
        chk("t2_gap1", starts_q.size() >= 2 ? starts_q[1] - starts_q[0] : -1, 10*C);
        chk("t2_gap2", starts_q.size() >= 3 ? starts_q[2] - starts_q[1] : -1, 10*C);
        chk("t2_overflow", overflow, 0);

        // Twenty reads while idle: shifter plus full queue take 17, the rest drop.
        for (int i = 0; i < 20; i++) bdat[i] = 8'h40 + 8'(i);
        f0 = frames;
        burst(20, DEPTH + 1, e0);
        chk("t3_overflow", overflow, 1);
        chk("t3_level", fifo_level, DEPTH);
        wait_drain("t3", 3000);
        chk("t3_frames", frames - f0, DEPTH + 1);
        chk("t3_overflow_sticky", overflow, 1);

        // Reset in the middle of data bit 3 of a 0xA5 frame with more bytes queued.
        bdat[0] = 8'hA5; bdat[1] = 8'h11; bdat[2] = 8'h22;
        burst(3, 3, e0);
        er = e0 + RL + 1 + 4*C + C/2;
        step_to(er);
        chk("t4_tx_bit3", tx, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        chk("t4_tx", tx, 1);
        chk("t4_busy", busy, 0);
        chk("t4_level", fifo_level, 0);
        chk("t4_overflow", overflow, 0);
        reset = 1'b1;
        bad = 0; bad2 = 0;
        for (int k = 0; k < 30*C; k++) begin
            if (tx !== 1'b1) bad++;
            if (busy !== 1'b0) bad2++;
            @(posedge clk); #1;
        end
        chk("t4_line_quiet", bad, 0);
        chk("t4_busy_quiet", bad2, 0);

        // Full queue: a push landing on the stop-end pop edge is kept and goes out last.
        for (int i = 0; i < 17; i++) bdat[i] = 8'h60 + 8'(i);
        f0 = frames;
        burst(17, 17, e0);
        er = e0 + 1 + 10*C;
        step_to(er);
        reg_read = 1'b1;
        exp_q.push_back(8'h99);
        @(posedge clk); #1;
        reg_read = 1'b0;
        for (int k = 0; k < RL - 1; k++) begin @(posedge clk); #1; end
        chk("t5_level_full_before", fifo_level, DEPTH);
        reg_data_out = 8'h99;
        @(posedge clk); #1;
        reg_data_out = 8'h00;
        chk("t5_level", fifo_level, DEPTH);
        chk("t5_overflow", overflow, 0);
        wait_drain("t5", 3000);
        chk("t5_frames", frames - f0, 18);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
